// File: rtl/radix4_seq_divider_if.sv
// radix4_seq_divider_if: start/busy/done handshake and operand/result bus of the radix-4 divider.
`timescale 1ns/1ps
interface radix4_seq_divider_if #(parameter int DW = 8);
   logic            start;
   logic [2*DW-1:0] dividend;
   logic [DW-1:0]   divisor;
   logic            busy;
   logic            done;
   logic [DW-1:0]   quotient;
   logic [DW-1:0]   remainder;
   logic            div_by_zero;
   logic            overflow;
   modport master (output start, dividend, divisor,
                   input busy, done, quotient, remainder, div_by_zero, overflow);
   modport slave  (input start, dividend, divisor,
                   output busy, done, quotient, remainder, div_by_zero, overflow);
endinterface

// File: rtl/radix4_seq_divider.sv
// radix4_seq_divider: sequential radix-4 restoring divider, 2*DW/DW -> DW quotient and remainder, 2 bits per clock.
// Define RADIX4_DIV_SIGNED_EN for two's-complement operands (truncating division, remainder follows dividend sign).
`timescale 1ns/1ps
module radix4_seq_divider #(parameter int DW = 8) (
   input logic                 clk,
   input logic                 rst_n,
   radix4_seq_divider_if.slave bus
);
   localparam int NW = DW + 2;
   localparam int IT = DW / 2;
   localparam int CW = $clog2(IT) + 1;
   typedef enum logic [1:0] {IDLE, CHECK, RUN, DONE} state_t;
   state_t          r_state;
   logic [2*DW-1:0] r_a;
   logic [DW-1:0]   r_b, r_lo, r_q, r_rem;
   logic [NW-1:0]   r_r, r_d1, r_d2, r_d3;
   logic [CW-1:0]   r_iter;
   logic            r_busy, r_done, r_dbz, r_ovf;
   logic [2*DW-1:0] w_num;
   logic [DW-1:0]   w_den, w_qn, w_fq, w_fr;
   logic [NW-1:0]   w_d1, w_d2, w_t, w_sub, w_rn;
   logic [1:0]      w_dig;
   logic            w_fovf;
   assign w_d1  = {2'b00, w_den};
   assign w_d2  = {1'b0, w_den, 1'b0};
   assign w_t   = {r_r[DW-1:0], r_lo[DW-1:DW-2]};
   assign w_dig = (w_t >= r_d3) ? 2'd3 : (w_t >= r_d2) ? 2'd2 : (w_t >= r_d1) ? 2'd1 : 2'd0;
   assign w_sub = (w_dig == 2'd3) ? r_d3 : (w_dig == 2'd2) ? r_d2 : (w_dig == 2'd1) ? r_d1 : '0;
   assign w_rn  = w_t - w_sub;
   assign w_qn  = {r_q[DW-3:0], w_dig};
`ifdef RADIX4_DIV_SIGNED_EN
   localparam logic [DW-1:0] HALF = DW'(1) << (DW - 1);
   logic r_nneg, r_qneg;
   assign w_num  = r_a[2*DW-1] ? -r_a : r_a;
   assign w_den  = r_b[DW-1] ? -r_b : r_b;
   assign w_fq   = r_qneg ? -w_qn : w_qn;
   assign w_fr   = r_nneg ? -w_rn[DW-1:0] : w_rn[DW-1:0];
   assign w_fovf = r_qneg ? (w_qn > HALF) : (w_qn >= HALF);
   // operand signs captured while magnitudes are formed, used for the final fix-up
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_nneg <= 1'b0;
         r_qneg <= 1'b0;
      end else if (r_state == CHECK) begin
         r_nneg <= r_a[2*DW-1];
         r_qneg <= r_a[2*DW-1] ^ r_b[DW-1];
      end
   end
`else
   assign w_num  = r_a;
   assign w_den  = r_b;
   assign w_fq   = w_qn;
   assign w_fr   = w_rn[DW-1:0];
   assign w_fovf = 1'b0;
`endif
   // control FSM and datapath: accept, screen exceptions, iterate radix-4 digits, publish results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_lo    <= '0;
         r_q     <= '0;
         r_rem   <= '0;
         r_r     <= '0;
         r_d1    <= '0;
         r_d2    <= '0;
         r_d3    <= '0;
         r_iter  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_dbz   <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE, DONE: begin
               r_state <= IDLE;
               if (bus.start) begin
                  r_a     <= bus.dividend;
                  r_b     <= bus.divisor;
                  r_q     <= '0;
                  r_rem   <= '0;
                  r_dbz   <= 1'b0;
                  r_ovf   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= CHECK;
               end
            end
            CHECK: begin
               if (w_den == '0) begin
                  r_dbz   <= 1'b1;
                  r_q     <= '1;
                  r_rem   <= r_a[DW-1:0];
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (w_num[2*DW-1:DW] >= w_den) begin
                  r_ovf   <= 1'b1;
                  r_q     <= '1;
                  r_rem   <= '1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_r     <= {2'b00, w_num[2*DW-1:DW]};
                  r_lo    <= w_num[DW-1:0];
                  r_d1    <= w_d1;
                  r_d2    <= w_d2;
                  r_d3    <= w_d1 + w_d2;
                  r_iter  <= '0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_r    <= w_rn;
               r_lo   <= {r_lo[DW-3:0], 2'b00};
               r_q    <= w_qn;
               r_iter <= r_iter + 1'b1;
               if (r_iter == CW'(IT - 1)) begin
                  r_q     <= w_fovf ? '1 : w_fq;
                  r_rem   <= w_fovf ? '1 : w_fr;
                  r_ovf   <= w_fovf;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.quotient    = r_q;
   assign bus.remainder   = r_rem;
   assign bus.div_by_zero = r_dbz;
   assign bus.overflow    = r_ovf;
endmodule
